// File: rtl/fb_blend_mem.sv
// Framebuffer store with write-first blend read port and sequential clear engine.
// Read latency 2 cycles, no read backpressure; write stream stalls (ready low) only while clearing.
package fb_blend_pkg;
  typedef logic [15:0] rgb565_t;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        valid;
  } fragment_t;
endpackage

module fb_blend_mem
  import fb_blend_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  // One spare code for power-of-two sizes so out-of-range coordinates stay expressible.
  localparam int XW = $clog2(FB_WIDTH + 1),
  localparam int YW = $clog2(FB_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  fragment_t     frag_in,
  input  rgb565_t       color_in,
  input  logic          frag_in_valid,
  output logic          frag_in_ready,
  input  logic [XW-1:0] blend_read_x,
  input  logic [YW-1:0] blend_read_y,
  input  logic          blend_read_en,
  output rgb565_t       blend_read_data,
  output logic          blend_read_valid,
  input  logic          clear_start,
  input  rgb565_t       clear_color,
  output logic          clear_busy,
  output logic          clear_done
);
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int AW = $clog2(NPIX);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  rgb565_t       clr_color;
  rgb565_t       mem [NPIX];

  logic          wr_in_range, wr_commit, we;
  logic [AW-1:0] wr_addr, rd_addr;
  rgb565_t       wr_dat;
  logic          rd_in_range;

  logic          s1_vld, s1_oob, s1_fwd;
  logic [AW-1:0] s1_addr;
  rgb565_t       s1_fwd_dat;

  assign frag_in_ready = (state == IDLE);

  always_comb begin
    wr_in_range = (32'(frag_in.x) < FB_WIDTH) && (32'(frag_in.y) < FB_HEIGHT);
    wr_commit   = frag_in_valid && frag_in_ready && frag_in.valid && wr_in_range;
    rd_in_range = (32'(blend_read_x) < FB_WIDTH) && (32'(blend_read_y) < FB_HEIGHT);
    rd_addr     = AW'(32'(blend_read_y) * FB_WIDTH + 32'(blend_read_x));
    if (state == CLEAR) begin
      we      = 1'b1;
      wr_addr = clr_cnt;
      wr_dat  = clr_color;
    end else begin
      we      = wr_commit;
      wr_addr = AW'(32'(frag_in.y) * FB_WIDTH + 32'(frag_in.x));
      wr_dat  = color_in;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_color  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_color  <= clear_color;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle write to the read address is captured so the result is write-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld           <= 1'b0;
      s1_oob           <= 1'b0;
      s1_fwd           <= 1'b0;
      s1_addr          <= '0;
      s1_fwd_dat       <= '0;
      blend_read_valid <= 1'b0;
      blend_read_data  <= '0;
    end else begin
      s1_vld <= blend_read_en;
      if (blend_read_en) begin
        s1_addr    <= rd_addr;
        s1_oob     <= !rd_in_range;
        s1_fwd     <= we && (wr_addr == rd_addr);
        s1_fwd_dat <= wr_dat;
      end
      blend_read_valid <= s1_vld;
      if (s1_vld) begin
        if (s1_oob)      blend_read_data <= '0;
        else if (s1_fwd) blend_read_data <= s1_fwd_dat;
        else             blend_read_data <= mem[s1_addr];
      end
    end
  end
endmodule

// File: tb/tb_fb_blend_mem.sv
// Directed bench for fb_blend_mem on an 8x4 framebuffer.
module tb_fb_blend_mem;
  import fb_blend_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XW = $clog2(W + 1);
  localparam int YW = $clog2(H + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  fragment_t     frag_in;
  rgb565_t       color_in;
  logic          frag_in_valid;
  logic          frag_in_ready;
  logic [XW-1:0] blend_read_x;
  logic [YW-1:0] blend_read_y;
  logic          blend_read_en;
  rgb565_t       blend_read_data;
  logic          blend_read_valid;
  logic          clear_start;
  rgb565_t       clear_color;
  logic          clear_busy;
  logic          clear_done;

  int errors = 0;
  int checks = 0;

  fb_blend_mem #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .frag_in(frag_in), .color_in(color_in),
    .frag_in_valid(frag_in_valid), .frag_in_ready(frag_in_ready),
    .blend_read_x(blend_read_x), .blend_read_y(blend_read_y),
    .blend_read_en(blend_read_en), .blend_read_data(blend_read_data),
    .blend_read_valid(blend_read_valid),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task set_wr(input int x, input int y, input rgb565_t c);
    frag_in.x = 16'(x);
    frag_in.y = 16'(y);
    frag_in.valid = 1'b1;
    color_in = c;
    frag_in_valid = 1'b1;
  endtask

  task clr_wr;
    frag_in_valid = 1'b0;
    frag_in.valid = 1'b0;
  endtask

  task set_rd(input int x, input int y);
    blend_read_x = XW'(x);
    blend_read_y = YW'(y);
    blend_read_en = 1'b1;
  endtask

  task write_px(input int x, input int y, input rgb565_t c);
    set_wr(x, y, c);
    step;
    clr_wr;
  endtask

  task read_px(input int x, input int y, output rgb565_t d, output logic v);
    set_rd(x, y);
    step;
    blend_read_en = 1'b0;
    step;
    d = blend_read_data;
    v = blend_read_valid;
  endtask

  // Starts a clear and observes busy/done/ready for a bounded window.
  task run_clear(input rgb565_t col, input bit inject, output int busy_n, output int done_n,
                 output int rdy_bad, output int done_pos, output int last_busy);
    busy_n = 0; done_n = 0; rdy_bad = 0; done_pos = -1; last_busy = -1;
    clear_color = col;
    clear_start = 1'b1;
    step;
    clear_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (clear_busy) begin busy_n++; last_busy = i; end
      if (clear_done) begin done_n++; done_pos = i; end
      if (frag_in_ready === clear_busy) rdy_bad++;
      if (inject && i == 5)  set_wr(0, 0, 16'h1234);
      if (inject && i == 10) clr_wr;
      step;
    end
  endtask

  task test_reset;
    repeat (2) step;
    checks++; if (blend_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", blend_read_valid); end
    checks++; if (blend_read_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", blend_read_data); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", clear_busy); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", clear_done); end
    rst_n = 1'b1;
    step;
    checks++; if (frag_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", frag_in_ready); end
  endtask

  task test_write_read;
    write_px(3, 2, 16'hF800);
    repeat (4) step;
    set_rd(3, 2);
    step;
    blend_read_en = 1'b0;
    checks++; if (blend_read_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid: got %b want 0", blend_read_valid); end
    step;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'hF800) begin errors++; $display("FAIL lat_n2: valid %b data %h want 1 F800", blend_read_valid, blend_read_data); end
    step;
    checks++; if (blend_read_valid !== 1'b0) begin errors++; $display("FAIL lat_n3_valid: got %b want 0", blend_read_valid); end
  endtask

  task test_forward;
    set_wr(1, 1, 16'h07E0);
    set_rd(1, 1);
    step;
    set_wr(1, 1, 16'h001F);
    step;
    clr_wr;
    blend_read_en = 1'b0;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'h07E0) begin errors++; $display("FAIL fwd_same_cycle: valid %b data %h want 1 07E0", blend_read_valid, blend_read_data); end
    step;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'h001F) begin errors++; $display("FAIL fwd_next_read: valid %b data %h want 1 001F", blend_read_valid, blend_read_data); end
  endtask

  task test_back_to_back;
    write_px(0, 0, 16'h1111);
    write_px(1, 0, 16'h2222);
    write_px(2, 0, 16'h3333);
    set_rd(0, 0);
    step;
    set_rd(1, 0);
    step;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'h1111) begin errors++; $display("FAIL b2b_0: valid %b data %h want 1 1111", blend_read_valid, blend_read_data); end
    set_rd(2, 0);
    step;
    blend_read_en = 1'b0;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'h2222) begin errors++; $display("FAIL b2b_1: valid %b data %h want 1 2222", blend_read_valid, blend_read_data); end
    step;
    checks++; if (blend_read_valid !== 1'b1 || blend_read_data !== 16'h3333) begin errors++; $display("FAIL b2b_2: valid %b data %h want 1 3333", blend_read_valid, blend_read_data); end
    step;
    checks++; if (blend_read_valid !== 1'b0 || blend_read_data !== 16'h3333) begin errors++; $display("FAIL b2b_hold: valid %b data %h want 0 3333", blend_read_valid, blend_read_data); end
  endtask

  task test_clear;
    int busy_n, done_n, rdy_bad, done_pos, last_busy;
    rgb565_t d;
    logic v;
    run_clear(16'hABCD, 1'b1, busy_n, done_n, rdy_bad, done_pos, last_busy);
    checks++; if (busy_n != 32) begin errors++; $display("FAIL clear_busy_len: got %0d want 32", busy_n); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL clear_done_count: got %0d want 1", done_n); end
    checks++; if (done_pos != last_busy + 1) begin errors++; $display("FAIL clear_done_pos: got %0d want %0d", done_pos, last_busy + 1); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL clear_ready: %0d cycles with ready equal to busy, want 0", rdy_bad); end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        read_px(x, y, d, v);
        checks++; if (v !== 1'b1 || d !== 16'hABCD) begin errors++; $display("FAIL clear_fill(%0d,%0d): valid %b data %h want 1 ABCD", x, y, v, d); end
      end
    end
  endtask

  task test_out_of_range;
    rgb565_t d;
    logic v;
    write_px(8, 0, 16'hBEEF);
    write_px(0, 4, 16'hBEEF);
    read_px(0, 1, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hABCD) begin errors++; $display("FAIL oob_wr_x: (0,1) valid %b data %h want 1 ABCD", v, d); end
    read_px(0, 0, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hABCD) begin errors++; $display("FAIL oob_wr_y: (0,0) valid %b data %h want 1 ABCD", v, d); end
    read_px(8, 0, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL oob_rd_x: valid %b data %h want 1 0000", v, d); end
    read_px(0, 4, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL oob_rd_y: valid %b data %h want 1 0000", v, d); end
  endtask

  task test_reset_mid_clear;
    int busy_n, done_n, rdy_bad, done_pos, last_busy, stray;
    rgb565_t d;
    logic v;
    read_px(2, 0, d, v);
    clear_color = 16'h5A5A;
    clear_start = 1'b1;
    step;
    clear_start = 1'b0;
    set_rd(2, 0);
    repeat (9) step;
    rst_n = 1'b0;
    #1;
    blend_read_en = 1'b0;
    checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_flags: busy %b done %b want 0 0", clear_busy, clear_done); end
    checks++; if (blend_read_valid !== 1'b0 || blend_read_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_clear_read: valid %b data %h want 0 0000", blend_read_valid, blend_read_data); end
    repeat (2) step;
    rst_n = 1'b1;
    #1;
    checks++; if (frag_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_clear_ready: got %b want 1", frag_in_ready); end
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (clear_done || clear_busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_clear_stray: %0d cycles busy or done, want 0", stray); end
    run_clear(16'h5A5A, 1'b0, busy_n, done_n, rdy_bad, done_pos, last_busy);
    checks++; if (busy_n != 32) begin errors++; $display("FAIL reclear_busy_len: got %0d want 32", busy_n); end
    checks++; if (done_n != 1 || done_pos != last_busy + 1) begin errors++; $display("FAIL reclear_done: count %0d pos %0d want 1 at %0d", done_n, done_pos, last_busy + 1); end
    read_px(7, 3, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h5A5A) begin errors++; $display("FAIL reclear_fill: valid %b data %h want 1 5A5A", v, d); end
  endtask

  initial begin
    frag_in = '0;
    color_in = '0;
    frag_in_valid = 1'b0;
    blend_read_x = '0;
    blend_read_y = '0;
    blend_read_en = 1'b0;
    clear_start = 1'b0;
    clear_color = '0;
    test_reset;
    test_write_read;
    test_forward;
    test_back_to_back;
    test_clear;
    test_out_of_range;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
